mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 111 +++++++++++
 tb/tb_mem_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Data-memory stage: multi-cycle load/store FSM (IDLE/BUSY/DONE) that stalls the pipeline.
// Optional macro DMEM_ALIGN_CHECK_EN adds misalign_o and suppresses misaligned accesses.
module mem_stage #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] MemRdata_o,
  output logic        stall_o,
  output logic        busy_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [3:0]    r_cnt, w_cnt_d;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_is_write;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic w_req;
  logic w_latch;
  logic w_access;
  logic w_ok;
  logic w_unused_addr;

  assign w_req = MemRead_i | MemWrite_i;
  // Address bits outside the word index are deliberately dropped (wrap modulo DEPTH*4).
  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_misalign;
  assign w_ok       = ~r_misalign;
  assign misalign_o = (r_state == StDone) && r_misalign;
`else
  assign w_ok = 1'b1;
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_latch   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_state_d = StBusy;
          w_cnt_d   = 4'(LAT - 1);
          w_latch   = 1'b1;
        end
      end
      StBusy: begin
        if (r_cnt == 4'd0) w_state_d = StDone;
        else               w_cnt_d   = r_cnt - 4'd1;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Access fires on the last BUSY edge; reset at that same edge aborts it.
  assign w_access = (r_state == StBusy) && (r_cnt == 4'd0) && !rst_i && w_ok;

  assign stall_o = !rst_i && ((r_state == StBusy) || ((r_state == StIdle) && w_req));
  assign busy_o  = (r_state != StIdle);
  assign MemRdata_o = r_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_rdata    <= 32'h0;
      r_idx      <= '0;
      r_wdata    <= 32'h0;
      r_is_write <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_latch) begin
        r_idx      <= addr_i[AW+1:2];
        r_wdata    <= wdata_i;
        r_is_write <= MemWrite_i;
`ifdef DMEM_ALIGN_CHECK_EN
        r_misalign <= |addr_i[1:0];
`endif
      end
      if (w_access && !r_is_write) r_rdata <= r_mem[r_idx];
    end
  end

  // Memory array has no reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (w_access && r_is_write) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (LAT=2, DEPTH=256).
// Define DMEM_ALIGN_CHECK_EN to exercise the misalignment option.
module tb_mem_stage;

  logic        clk;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] MemRdata_o;
  logic        stall_o;
  logic        busy_o;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int unsigned n_pass;
  int unsigned n_total;

  mem_stage #(
    .LAT  (2),
    .DEPTH(256)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .MemRead_i (MemRead_i),
    .MemWrite_i(MemWrite_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .MemRdata_o(MemRdata_o),
    .stall_o   (stall_o),
    .busy_o    (busy_o)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic mis_now();
`ifdef DMEM_ALIGN_CHECK_EN
    return misalign_o;
`else
    return 1'b0;
`endif
  endfunction

  // Entered and left just after a rising edge with the FSM in IDLE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata_done, output logic mis_done);
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = d;
    #1;
    check({tag, "/idle_stall"}, {31'b0, stall_o}, 32'd1);
    check({tag, "/idle_busy"}, {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    // Scramble inputs: the latched request must be used.
    MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = a ^ 32'h40; wdata_i = ~d;
    check({tag, "/busy1_stall"}, {31'b0, stall_o}, 32'd1);
    check({tag, "/busy1_mis"}, {31'b0, mis_now()}, 32'd0);
    @(posedge clk); #1;
    check({tag, "/busy0_stall"}, {31'b0, stall_o}, 32'd1);
    @(posedge clk); #1;
    check({tag, "/done_stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, "/done_busy"}, {31'b0, busy_o}, 32'd1);
    rdata_done = MemRdata_o;
    mis_done   = mis_now();
    @(posedge clk); #1;
    check({tag, "/after_busy"}, {31'b0, busy_o}, 32'd0);
    check({tag, "/after_mis"}, {31'b0, mis_now()}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    n_pass = 0; n_total = 0;
    rst_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall_low", {31'b0, stall_o}, 32'd0);
    check("rst_busy_low", {31'b0, busy_o}, 32'd0);
    check("rst_rdata", MemRdata_o, 32'h0);
    MemRead_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", {31'b0, busy_o}, 32'd0);

    access("init20", 1'b0, 1'b1, 32'h20, 32'h1111_2222, rd, mis);
    access("st10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, mis);
    check("st10_rdata_unchanged", rd, 32'h0);
    access("ld10", 1'b1, 1'b0, 32'h10, 32'h0, rd, mis);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);
    check("ld10_rdata_hold", MemRdata_o, 32'hDEAD_BEEF);

    // Held load: second access begins only after IDLE; address changed mid-flight.
    MemRead_i = 1'b1; addr_i = 32'h10;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("b2b_stall%0d", i), {31'b0, stall_o}, ((i % 4) != 3) ? 32'd1 : 32'd0);
      if (i == 1) addr_i = 32'h20;
      if (i == 3) check("b2b_rdata1", MemRdata_o, 32'hDEAD_BEEF);
      if (i == 7) begin
        check("b2b_rdata2", MemRdata_o, 32'h1111_2222);
        MemRead_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("b2b_idle", {31'b0, busy_o}, 32'd0);

    // Reset in the second BUSY cycle aborts the store.
    MemWrite_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    MemWrite_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    check("abort_stall_in_rst", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_rdata_zero", MemRdata_o, 32'h0);
    access("ld20", 1'b1, 1'b0, 32'h20, 32'h0, rd, mis);
    check("ld20_prior", rd, 32'h1111_2222);

    access("both04", 1'b1, 1'b1, 32'h04, 32'hA5A5_A5A5, rd, mis);
    check("both04_rdata_kept", rd, 32'h1111_2222);
    access("ld04", 1'b1, 1'b0, 32'h04, 32'h0, rd, mis);
    check("ld04_rdata", rd, 32'hA5A5_A5A5);

    access("st400", 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, rd, mis);
    access("ld000", 1'b1, 1'b0, 32'h000, 32'h0, rd, mis);
    check("wrap_rdata", rd, 32'hCAFE_F00D);
    check("wrap_mis", {31'b0, mis}, 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    access("st13", 1'b0, 1'b1, 32'h13, 32'hBAD0_BAD0, rd, mis);
    check("st13_mis_done", {31'b0, mis}, 32'd1);
    access("ld12", 1'b1, 1'b0, 32'h12, 32'h0, rd, mis);
    check("ld12_mis_done", {31'b0, mis}, 32'd1);
    check("ld12_rdata_kept", rd, 32'hCAFE_F00D);
    access("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, rd, mis);
    check("ld10b_rdata", rd, 32'hDEAD_BEEF);
    check("ld10b_mis", {31'b0, mis}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
